// File: rtl/fsm_pkg.sv
// Shared types and constants for the input conditioning stage.
package fsm_pkg;

  typedef logic [1:0] code_t;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  typedef enum logic [1:0] {
    CH_G1 = 2'd0,
    CH_G2 = 2'd1,
    CH_A  = 2'd2,
    CH_P  = 2'd3
  } ch_idx_e;

endpackage

// File: rtl/fsm_input_cond_debounce_ch.sv
// One debounce channel: candidate tracking, saturating run counter and
// the accepted stable code with its one-cycle change strobe.
module debounce_ch
  import fsm_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  code_t sample,
  output code_t stable,
  output logic  chg,
  output logic  sat
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  code_t            cand;
  logic [CNT_W-1:0] cnt;

  // Candidate/count/stable update; frozen while en is low, strobe cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
      chg    <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (en) begin
        if (sample != cand) begin
          cand <= sample;
          cnt  <= '0;
        end else if (cnt < CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end else if (cand != stable) begin
          stable <= cand;
          chg    <= 1'b1;
        end
      end
    end
  end

  // Saturation flag feeds the parent's settle detection.
  always_comb begin
    sat = (cnt == CNT_MAX);
  end

endmodule

// File: rtl/fsm_input_cond.sv
// Input conditioning: 2-flop synchroniser on the raw pins, four debounce
// channels and a sticky valid flag once every channel has settled.
module fsm_input_cond
  import fsm_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_CH*CH_W-1:0] raw_in,
  output code_t                g1,
  output code_t                g2,
  output code_t                a,
  output code_t                p,
  output logic [N_CH-1:0]      chg,
  output logic                 valid
);

  logic [N_CH*CH_W-1:0] sync1;
  logic [N_CH*CH_W-1:0] sync2;
  code_t                stab [N_CH];
  logic [N_CH-1:0]      sat;

  // Synchroniser runs regardless of en so no samples are lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .sample (sync2[CH_W*i +: CH_W]),
      .stable (stab[i]),
      .chg    (chg[i]),
      .sat    (sat[i])
    );
  end

  // Valid latches one edge after all channels are saturated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (&sat) begin
      valid <= 1'b1;
    end
  end

  // Channel codes routed to the FSM request inputs.
  always_comb begin
    g1 = stab[CH_G1];
    g2 = stab[CH_G2];
    a  = stab[CH_A];
    p  = stab[CH_P];
  end

endmodule

// File: doc/fsm_input_cond.md
# fsm_input_cond

Input conditioning stage that sits directly upstream of the controller FSM in the `tt_um_*` top. It synchronises the eight raw `ui_in` pins and debounces them as four 2-bit request channels: G1, G2, A and P. It presents a stable, glitch-free code per channel to the FSM. It also raises a one-cycle change strobe for each channel and a sticky `valid` flag once every channel has settled after reset.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: number of consecutive identical synchronised samples required to accept a new code. Legal range is 2..16.

Ports:
- `clk`  in  1: system clock. This is the single clock domain.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `en`  in  1: enable, driven from top-level `ena`. When 0, debounce state freezes.
- `raw_in`  in  8: asynchronous pins. Bits [1:0] are G1, [3:2] are G2, [5:4] are A, [7:6] are P.
- `g1`, `g2`, `a`, `p`  out  2 each: debounced stable codes fed to the FSM.
- `chg`  out  4: one-cycle strobe per channel, ordered as bit0 G1, bit1 G2, bit2 A, bit3 P.
- `valid`  out  1: sticky; set once all channels have settled after reset.

## Operation
- **Synchroniser:** a 2-flop synchroniser on all 8 bits (`sync1`, `sync2`). It runs regardless of `en`.
- **Per-channel state:** candidate `cand[1:0]`, saturating counter `cnt` (width `$clog2(DEB_CYCLES)`), and `stable[1:0]`.
- **Update rule**, each edge with `en`=1 (all three operate on the same `cand`, `cnt`, `stable`; the 2-bit codes in `cand` and `stable` are compared as whole codes):
  - If `sync2` ≠ `cand`: `cand`←`sync2` and `cnt`←0.
  - Else if `cnt` < DEB_CYCLES-1: `cnt`←`cnt`+1.
  - Else, when `cnt` == DEB_CYCLES-1 and `cand` ≠ `stable`: `stable`←`cand` and `chg` bit←1. `cnt` stays saturated.
- **Strobe width:** every `chg` bit is 0 on any cycle where it was not set by the update rule above.
- **Bounce back to the old value:** a bounce that returns to the prior stable code resets `cand` and `cnt`. It then re-settles with `cand` == `stable`, so no update and no strobe occur.
- **`en`=0:** `cand`, `cnt` and `stable` hold, and `chg` is forced to 0. The synchroniser keeps sampling.
- **`valid`:** set to 1 on the edge after all four `cnt` are simultaneously saturated. It stays at 1 until reset.
- **Reset values:** `sync1`, `sync2`, `cand`, `cnt`, `stable`, `chg` and `valid` are all 0. Reset is effective immediately on `rst_n` falling, including mid-count; no strobe is emitted for a count that reset aborts.
- **Channel independence:** simultaneous changes on several channels are handled independently. Strobes may coincide in the same cycle.

## Timing
- **Clean change:** raw changes before edge 1 and then holds.
  - `sync2` updates at edge 2.
  - `cand` loads at edge 3.
  - `cnt` saturates at edge DEB_CYCLES+2.
  - `stable` and `chg` update at edge DEB_CYCLES+3; this is 7 edges for the default.
- **Glitch rejection:** a pulse shorter than DEB_CYCLES sampled cycles never reaches `stable`.
- **`en` low:** each `en`-low cycle during a count delays acceptance by exactly one cycle.
- **`valid` after reset:** after `rst_n` rises with raw = 0, `valid` rises at edge DEB_CYCLES; this is edge 4 for the default.
- **Output registers:** all outputs are registered. There are no combinational paths from input to output.

## Structure
- Package `fsm_pkg` holds:
  - `typedef logic [1:0] code_t`
  - `localparam N_CH = 4`
  - `localparam CH_W = 2`
  - channel index enum: `CH_G1`=0, `CH_G2`, `CH_A`, `CH_P`
- Sub-module `debounce_ch`: one channel's `cand`/`cnt`/`stable`/`chg` logic, parameterised by `DEB_CYCLES`.
  - Instantiated four times in a generate loop.
  - The synchroniser and the `valid` logic live in the parent.
- The top ties `g1`/`g2`/`a`/`p` to the FSM request inputs.

## Test plan
- **Reset:** hold `rst_n`=0 with `raw_in`=8'hFF → all outputs 0. Release with raw=0 → `valid`=1 at edge 4, `chg`=0 throughout.
- **Clean change:** G1 raw 00→10 held, DEB=4 → `g1`=2'b10 and `chg`=4'b0001 for exactly one cycle at edge 7. Other channels are unchanged.
- **Glitch:** A raw pulsed to 11 for 3 cycles, then back to 00 → `a` stays 00 and `chg[2]` never asserts.
- **Simultaneous change:** all channels change raw 00→01 on the same cycle → `chg`=4'b1111 for one cycle at edge 7, and all codes become 01.
- **Enable freeze:** P raw 00→11 with `en` dropped for 5 cycles mid-count → `p` updates at edge 12, not 7. `chg` stays 0 while `en`=0.
- **Reset mid-count:** assert `rst_n`=0 two cycles before acceptance → outputs go to 0 asynchronously and no strobe is seen. After release, the held raw code is accepted DEB_CYCLES+3 edges later.
